// File: rtl/digital_bit_buffer.sv
// Byte-to-bit staging buffer: collects one frame of bytes, then serves the bits MSB first
// to a pull-style consumer (one bit per rising edge of bitRequest).
`timescale 1ns/1ps
module digital_bit_buffer #(
  parameter int unsigned BUF_BITS  = 10240,
  parameter int unsigned BUF_BYTES = BUF_BITS / 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  input  logic        bitRequest,
  output logic        bitData,
  output logic [14:0] bitsUsed,
  output logic        overflow,
  output logic [15:0] droppedBytes
);

  localparam int unsigned AW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int unsigned CW = 15;
  localparam logic [CW-1:0] FULL_M1   = CW'(BUF_BITS - 1);
  localparam logic [CW-1:0] FULL_M8   = CW'(BUF_BITS - 8);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BUF_BYTES - 1);

  typedef enum logic [1:0] {S_FILL, S_LOAD1, S_LOAD2, S_DRAIN} state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_addr_q;
  logic [AW-1:0]   rd_addr_q;
  logic [7:0]      sh_q;
  logic [7:0]      next_byte_q;
  logic [7:0]      rd_data_q;
  logic [2:0]      bit_idx_q;
  logic [CW-1:0]   bits_taken_q;
  logic [CW-1:0]   bits_used_q;
  logic            rq_prev_q;
  logic            edge_q;
  logic            fetch_pend_q;
  logic            overflow_q;
  logic [15:0]     dropped_q;
  logic [7:0]      mem_q [BUF_BYTES];

  logic            wr_en_c;
  logic            drop_c;
  logic            take_c;
  logic            last_take_c;
  logic            wrap_c;
  logic            rd_en_c;
  logic [AW-1:0]   rd_addr_c;

  // Event decode and RAM read-port steering
  always_comb begin
    wr_en_c     = (state_q == S_FILL) && byteValid;
    drop_c      = (state_q != S_FILL) && byteValid;
    take_c      = (state_q == S_DRAIN) && edge_q;
    last_take_c = take_c && (bits_taken_q == FULL_M1);
    wrap_c      = take_c && (bit_idx_q == 3'd7) && !last_take_c;
    rd_en_c     = 1'b0;
    rd_addr_c   = '0;
    case (state_q)
      S_LOAD1: begin
        rd_en_c   = 1'b1;
        rd_addr_c = AW'(0);
      end
      S_LOAD2: begin
        rd_en_c   = 1'b1;
        rd_addr_c = AW'(1);
      end
      S_DRAIN: begin
        rd_en_c   = wrap_c;
        rd_addr_c = rd_addr_q;
      end
      default: ;
    endcase
  end

  // Frame storage: synchronous write, 1-cycle registered read
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_addr_q] <= byteIn;
    if (rd_en_c) rd_data_q <= mem_q[rd_addr_c];
  end

  // Control FSM, pointers, shift register and prefetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      sh_q         <= '0;
      next_byte_q  <= '0;
      bit_idx_q    <= '0;
      bits_taken_q <= '0;
      bits_used_q  <= '0;
      rq_prev_q    <= 1'b0;
      edge_q       <= 1'b0;
      fetch_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rq_prev_q    <= bitRequest;
      edge_q       <= bitRequest & ~rq_prev_q;
      overflow_q   <= drop_c;
      fetch_pend_q <= 1'b0;
      if (fetch_pend_q) next_byte_q <= rd_data_q;
      case (state_q)
        S_FILL: begin
          if (byteValid) begin
            bits_used_q <= bits_used_q + CW'(8);
            if (bits_used_q == FULL_M8) state_q <= S_LOAD1;
            else                        wr_addr_q <= wr_addr_q + AW'(1);
          end
        end
        S_LOAD1: state_q <= S_LOAD2;
        S_LOAD2: begin
          sh_q         <= rd_data_q;
          fetch_pend_q <= 1'b1;
          rd_addr_q    <= AW'(2);
          bit_idx_q    <= '0;
          bits_taken_q <= '0;
          state_q      <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_take_c) begin
            bits_used_q  <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            sh_q         <= '0;
            bit_idx_q    <= '0;
            bits_taken_q <= '0;
            state_q      <= S_FILL;
          end else if (take_c) begin
            bits_taken_q <= bits_taken_q + CW'(1);
            bit_idx_q    <= bit_idx_q + 3'd1;
            if (wrap_c) begin
              // Byte boundary: swap in the prefetched byte and refetch behind it
              sh_q         <= next_byte_q;
              fetch_pend_q <= 1'b1;
              if (rd_addr_q != LAST_ADDR) rd_addr_q <= rd_addr_q + AW'(1);
            end else begin
              sh_q <= {sh_q[6:0], 1'b0};
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  // Saturating dropped-byte counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped_q <= '0;
    end else if (drop_c && (dropped_q != 16'hFFFF)) begin
      dropped_q <= dropped_q + 16'd1;
    end
  end

  assign bitData      = sh_q[7];
  assign bitsUsed     = bits_used_q;
  assign overflow     = overflow_q;
  assign droppedBytes = dropped_q;

endmodule

// File: tb/tb_digital_bit_buffer.sv
// Scoreboard bench for digital_bit_buffer: stimulus queues expected bits, a negedge
// monitor pops one per consumer request edge and compares against bitData.
`timescale 1ns/1ps
module tb_digital_bit_buffer;

  localparam int unsigned BUF_BITS  = 10240;
  localparam int unsigned BUF_BYTES = BUF_BITS / 8;

  logic        clk;
  logic        reset;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        bitRequest;
  logic        bitData;
  logic [14:0] bitsUsed;
  logic        overflow;
  logic [15:0] droppedBytes;

  digital_bit_buffer #(.BUF_BITS(BUF_BITS), .BUF_BYTES(BUF_BYTES)) dut (
    .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid),
    .bitRequest(bitRequest), .bitData(bitData), .bitsUsed(bitsUsed),
    .overflow(overflow), .droppedBytes(droppedBytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_seen = 0;
  bit mon_en   = 1'b0;
  bit req_prev_m = 1'b0;
  bit exp_q[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: consumer samples bitData in the cycle it raises bitRequest
  always @(negedge clk) begin
    if (overflow) ovf_seen++;
    if (mon_en && bitRequest && !req_prev_m) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL bitstream: request edge with no expected bit (t=%0t)", $time);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("bitData", 32'(bitData), 32'(e));
      end
    end
    req_prev_m = bitRequest;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one frame; expected bits are queued MSB first as each byte is issued
  task automatic fill_frame(input bit all_ones, input int gap, input bit check_steps);
    logic [7:0] b;
    for (int i = 0; i < int'(BUF_BYTES); i++) begin
      b = all_ones ? 8'hFF : 8'(i);
      for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
      byteIn    = b;
      byteValid = 1'b1;
      tick();
      byteValid = 1'b0;
      if (check_steps) check("bitsUsed step", 32'(bitsUsed), 32'((i + 1) * 8));
      if (i != int'(BUF_BYTES) - 1) repeat (gap - 1) tick();
    end
  endtask

  // Request pulses; optional level hold and dropped-byte strobes in the low phase
  task automatic drain_bits(input int n, input int hi, input int lo, input int hold_at,
                            input bit strobes);
    for (int k = 0; k < n; k++) begin
      bitRequest = 1'b1;
      repeat ((k == hold_at) ? 10 : hi) tick();
      bitRequest = 1'b0;
      if (strobes && (k == 100 || k == 200 || k == 300)) begin
        byteIn    = 8'h5A;
        byteValid = 1'b1;
        tick();
        byteValid = 1'b0;
        repeat (lo - 1) tick();
      end else begin
        repeat (lo) tick();
      end
    end
  endtask

  task automatic drain_final(input int hi);
    bitRequest = 1'b1;
    tick();
    check("bitsUsed before final take", 32'(bitsUsed), BUF_BITS);
    if (hi == 1) bitRequest = 1'b0;
    tick();
    check("bitsUsed after final take", 32'(bitsUsed), 0);
    check("bitData after final take", 32'(bitData), 0);
    bitRequest = 1'b0;
    repeat (2) tick();
    check("expected bits all consumed", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; byteIn = 8'h00; byteValid = 1'b0; bitRequest = 1'b0;
    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      byteIn = 8'hA5 ^ 8'(i); byteValid = ~byteValid; bitRequest = ~bitRequest;
      tick();
    end
    check("reset bitData", 32'(bitData), 0);
    check("reset bitsUsed", 32'(bitsUsed), 0);
    check("reset overflow", 32'(overflow), 0);
    check("reset droppedBytes", 32'(droppedBytes), 0);
    byteValid = 1'b0; bitRequest = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Requests during FILL are ignored
    for (int i = 0; i < 3; i++) begin
      bitRequest = 1'b1; repeat (2) tick();
      bitRequest = 1'b0; repeat (2) tick();
    end
    check("FILL request bitData", 32'(bitData), 0);
    check("FILL request bitsUsed", 32'(bitsUsed), 0);

    // Frame A: i mod 256, strobes every 3 cycles, packer-style drain
    fill_frame(1'b0, 3, 1'b1);
    check("bitsUsed full", 32'(bitsUsed), BUF_BITS);
    repeat (2) tick();
    check("first bit of frame A", 32'(bitData), 0);
    mon_en = 1'b1;
    drain_bits(int'(BUF_BITS) - 1, 2, 2, 50, 1'b1);
    check("bitsUsed held in DRAIN", 32'(bitsUsed), BUF_BITS);
    drain_final(2);
    mon_en = 1'b0;
    check("overflow pulses frame A", 32'(ovf_seen), 3);
    check("droppedBytes frame A", 32'(droppedBytes), 3);

    // Frame B: back-to-back fill, partial drain, saturation, reset mid-drain
    fill_frame(1'b0, 1, 1'b0);
    check("bitsUsed full frame B", 32'(bitsUsed), BUF_BITS);
    repeat (3) tick();
    mon_en = 1'b1;
    drain_bits(2000, 1, 2, -1, 1'b0);
    force dut.dropped_q = 16'hFFFF;
    tick();
    release dut.dropped_q;
    byteIn = 8'h33; byteValid = 1'b1;
    tick();
    byteValid = 1'b0;
    check("overflow pulse high", 32'(overflow), 1);
    tick();
    check("overflow pulse low", 32'(overflow), 0);
    check("droppedBytes saturated", 32'(droppedBytes), 32'hFFFF);
    check("overflow pulses total", 32'(ovf_seen), 4);
    drain_bits(3000, 1, 2, -1, 1'b0);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("mid-drain reset bitsUsed", 32'(bitsUsed), 0);
    check("mid-drain reset bitData", 32'(bitData), 0);
    check("mid-drain reset droppedBytes", 32'(droppedBytes), 0);
    check("mid-drain reset overflow", 32'(overflow), 0);
    repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();

    // Frame C: all ones from address 0
    fill_frame(1'b1, 1, 1'b0);
    check("bitsUsed full frame C", 32'(bitsUsed), BUF_BITS);
    tick();
    check("bitData before first-bit latency", 32'(bitData), 0);
    tick();
    check("first bit of frame C", 32'(bitData), 1);
    mon_en = 1'b1;
    drain_bits(int'(BUF_BITS) - 1, 1, 2, -1, 1'b0);
    drain_final(1);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
